wb_accel_mux: RTL and testbench

WB_ACCEL_MUX -- requirements
Module: wb_accel_mux

---
 rtl/wb_accel_mux.sv | 220 ++++++++++++++++++++++
 tb/tb_wb_accel_mux.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_accel_mux.sv
// Wishbone slave that fans one upstream port out to NUM_CH accelerator
// channels, with a small control block (IRQ mask/pending, timeout status, ID).
module wb_accel_mux #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CH_ADDR_BITS = 12,
    parameter logic [7:0]  BASE_HI      = 8'h30,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_n,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_we_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    input  logic [3:0]                 wbs_sel_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    output logic [NUM_CH-1:0]          ch_cyc_o,
    output logic [NUM_CH-1:0]          ch_stb_o,
    output logic                       ch_we_o,
    output logic [3:0]                 ch_sel_o,
    output logic [CH_ADDR_BITS-1:0]    ch_adr_o,
    output logic [31:0]                ch_dat_o,
    input  logic [NUM_CH*32-1:0]       ch_dat_i,
    input  logic [NUM_CH-1:0]          ch_ack_i,
    input  logic [NUM_CH-1:0]          ch_irq_i,
    output logic [2:0]                 user_irq
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned DW       = 32;
    localparam logic [2:0]  CTRL_IDX = 3'd7;
    localparam logic [DW-1:0] BAD_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {S_IDLE, S_FWD, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [CH_ADDR_BITS-1:0] adr_q, adr_d;
    logic [DW-1:0]           dat_q, dat_d;
    logic [3:0]              sel_q, sel_d;
    logic                    we_q, we_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]           resp_q, resp_d;
    logic                    ack_q, ack_d;
    logic [DW-1:0]           rdat_q, rdat_d;
    logic [NUM_CH-1:0]       stb_q, stb_d;
    logic [NUM_CH-1:0]       mask_q, mask_d;
    logic [NUM_CH-1:0]       pend_q, pend_d;
    logic [NUM_CH-1:0]       tmo_q, tmo_d;
    logic [NUM_CH-1:0]       irq_prev_q;
    logic [1:0]              uirq_q;

    logic                    hit_c;
    logic [2:0]              hit_idx_c;
    logic [NUM_CH-1:0]       hit_onehot_c, cur_onehot_c;
    logic                    sel_ack_c;
    logic [DW-1:0]           sel_dat_c;
    logic [DW-1:0]           ctrl_rdata_c;
    logic [NUM_CH-1:0]       w1c_pend_c, w1c_tmo_c, tmo_set_c;
    logic                    unused_adr;

    assign unused_adr = &{1'b0, wbs_adr_i[23:CH_ADDR_BITS+3]};

    // Address decode, channel selection and control register read mux
    always_comb begin
        hit_c        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI) & ~ack_q;
        hit_idx_c    = wbs_adr_i[CH_ADDR_BITS+2:CH_ADDR_BITS];
        hit_onehot_c = '0;
        cur_onehot_c = '0;
        sel_ack_c    = 1'b0;
        sel_dat_c    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            hit_onehot_c[i] = (hit_idx_c == 3'(i));
            cur_onehot_c[i] = (idx_q == 3'(i));
            if (idx_q == 3'(i)) begin
                sel_ack_c = ch_ack_i[i];
                sel_dat_c = ch_dat_i[i*32 +: 32];
            end
        end
        case (adr_q[3:2])
            2'd0:    ctrl_rdata_c = DW'(mask_q);
            2'd1:    ctrl_rdata_c = DW'(pend_q);
            2'd2:    ctrl_rdata_c = DW'(tmo_q);
            default: ctrl_rdata_c = {24'h5D0C0A, 5'd0, 3'(NUM_CH)};
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        resp_d     = resp_q;
        ack_d      = 1'b0;
        rdat_d     = '0;
        stb_d      = stb_q;
        mask_d     = mask_q;
        w1c_pend_c = '0;
        w1c_tmo_c  = '0;
        tmo_set_c  = '0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (hit_c) begin
                    idx_d = hit_idx_c;
                    adr_d = wbs_adr_i[CH_ADDR_BITS-1:0];
                    dat_d = wbs_dat_i;
                    sel_d = wbs_sel_i;
                    we_d  = wbs_we_i;
                    if (32'(hit_idx_c) < NUM_CH) begin
                        state_d = S_FWD;
                        stb_d   = hit_onehot_c;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = S_RESP;
                        resp_d  = BAD_DATA;
                    end
                end
            end
            S_FWD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                    stb_d   = '0;
                    cnt_d   = '0;
                end else if (sel_ack_c) begin
                    state_d = S_RESP;
                    resp_d  = sel_dat_c;
                    stb_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    state_d   = S_RESP;
                    resp_d    = BAD_DATA;
                    tmo_set_c = cur_onehot_c;
                    stb_d     = '0;
                    cnt_d     = '0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                ack_d   = 1'b1;
                rdat_d  = (idx_q == CTRL_IDX) ? ctrl_rdata_c : resp_q;
                if (idx_q == CTRL_IDX && we_q && sel_q[0]) begin
                    case (adr_q[3:2])
                        2'd0:    mask_d     = dat_q[NUM_CH-1:0];
                        2'd1:    w1c_pend_c = dat_q[NUM_CH-1:0];
                        2'd2:    w1c_tmo_c  = dat_q[NUM_CH-1:0];
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new set event always beats a same-cycle clear
        pend_d = (pend_q & ~w1c_pend_c) | (ch_irq_i & ~irq_prev_q);
        tmo_d  = (tmo_q & ~w1c_tmo_c) | tmo_set_c;
    end

    // FSM state register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Datapath, status and output registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            idx_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            resp_q     <= '0;
            ack_q      <= 1'b0;
            rdat_q     <= '0;
            stb_q      <= '0;
            mask_q     <= '0;
            pend_q     <= '0;
            tmo_q      <= '0;
            irq_prev_q <= '0;
            uirq_q     <= '0;
        end else begin
            idx_q      <= idx_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            resp_q     <= resp_d;
            ack_q      <= ack_d;
            rdat_q     <= rdat_d;
            stb_q      <= stb_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            tmo_q      <= tmo_d;
            irq_prev_q <= ch_irq_i;
            uirq_q     <= {|tmo_q, |(pend_q & mask_q)};
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign ch_cyc_o  = stb_q;
    assign ch_stb_o  = stb_q;
    assign ch_we_o   = we_q;
    assign ch_sel_o  = sel_q;
    assign ch_adr_o  = adr_q;
    assign ch_dat_o  = dat_q;
    assign user_irq  = {1'b0, uirq_q};

endmodule

// File: tb/tb_wb_accel_mux.sv
// Self-checking bench for wb_accel_mux: vector table, random traffic against
// a register-level model, and hand-written timeout/IRQ/abort sequences.
module tb_wb_accel_mux;

    localparam int unsigned NCH = 4;
    localparam int unsigned TMO = 255;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cyc, stb, we;
    logic [31:0]       adr, wdat;
    logic [3:0]        sel;
    logic              ack;
    logic [31:0]       rdat;
    logic [NCH-1:0]    ch_cyc, ch_stb;
    logic              ch_we;
    logic [3:0]        ch_sel;
    logic [11:0]       ch_adr;
    logic [31:0]       ch_dat_o;
    logic [NCH*32-1:0] ch_dat_i;
    logic [NCH-1:0]    ch_ack, ch_irq;
    logic [2:0]        user_irq;

    logic [NCH-1:0]    ack_en;
    logic [NCH-1:0]    ack_force;
    logic [31:0]       chan_data [NCH];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state of the control registers
    logic [NCH-1:0] m_mask, m_pend, m_tmo;

    always #5 clk = ~clk;

    wb_accel_mux #(.NUM_CH(NCH), .CH_ADDR_BITS(12), .BASE_HI(8'h30), .TIMEOUT_CYC(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .ch_cyc_o(ch_cyc), .ch_stb_o(ch_stb), .ch_we_o(ch_we), .ch_sel_o(ch_sel),
        .ch_adr_o(ch_adr), .ch_dat_o(ch_dat_o), .ch_dat_i(ch_dat_i),
        .ch_ack_i(ch_ack), .ch_irq_i(ch_irq), .user_irq(user_irq)
    );

    // Channel responders: ack on the first strobe cycle when enabled
    always_comb begin
        ch_ack = (ch_stb & ack_en) | ack_force;
        for (int i = 0; i < NCH; i++) ch_dat_i[i*32 +: 32] = chan_data[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One Wishbone classic transfer; lat = edges from hit sample to ack, -1 if none
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input int bound,
                        output logic [31:0] rd, output int lat,
                        output logic [3:0] stb_seen, output logic [11:0] adr_seen,
                        output logic [31:0] cdat_seen);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        @(posedge clk); #1;
        lat = 0; stb_seen = '0; adr_seen = '0; cdat_seen = '0; rd = '0;
        while (!ack && lat < bound) begin
            if (ch_stb != 0 && stb_seen == 0) begin
                stb_seen = ch_stb; adr_seen = ch_adr; cdat_seen = ch_dat_o;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (ack) rd = rdat;
        else     lat = -1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (lat > 0) begin
            @(posedge clk); #1;
            check("ack_single_cycle", {31'd0, ack}, 32'd0);
            check("dat_zero_no_ack", rdat, 32'd0);
        end
    endtask

    function automatic logic [31:0] model_ctrl(input logic [1:0] off);
        case (off)
            2'd0:    return 32'(m_mask);
            2'd1:    return 32'(m_pend);
            2'd2:    return 32'(m_tmo);
            default: return 32'h5D0C_0A04;
        endcase
    endfunction

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic [3:0]  s;
        int          lat;
        logic [31:0] rd;
        logic [3:0]  stb;
        logic [11:0] cadr;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic [3:0] s, input int lat, input logic [31:0] rd,
                                input logic [3:0] stb, input logic [11:0] cadr);
        vec_t v;
        v.a = a; v.w = w; v.d = d; v.s = s; v.lat = lat; v.rd = rd; v.stb = stb; v.cadr = cadr;
        return v;
    endfunction

    initial begin
        vec_t        tbl [15];
        logic [31:0] r, cd;
        int          lat;
        logic [3:0]  sst;
        logic [11:0] sadr;

        chan_data[0] = 32'hC0DE_0000; chan_data[1] = 32'hC0DE_1111;
        chan_data[2] = 32'hC0DE_2222; chan_data[3] = 32'hC0DE_3333;
        ack_en = 4'b1011; ack_force = '0; ch_irq = '0;
        cyc = 0; stb = 0; we = 0; adr = '0; wdat = '0; sel = '0;

        tbl[0]  = mk(32'h3000_1004, 1, 32'h55, 4'hF, 2, 32'h0, 4'b0010, 12'h004);
        tbl[1]  = mk(32'h3000_0010, 0, 32'h0, 4'hF, 2, 32'hC0DE_0000, 4'b0001, 12'h010);
        tbl[2]  = mk(32'h3000_3FFC, 0, 32'h0, 4'hF, 2, 32'hC0DE_3333, 4'b1000, 12'hFFC);
        tbl[3]  = mk(32'h3000_5000, 0, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 4'b0000, 12'h0);
        tbl[4]  = mk(32'h3000_6000, 1, 32'h1234, 4'hF, 1, 32'h0, 4'b0000, 12'h0);
        tbl[5]  = mk(32'h3000_6000, 0, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 4'b0000, 12'h0);
        tbl[6]  = mk(32'h3000_700C, 0, 32'h0, 4'hF, 1, 32'h5D0C_0A04, 4'b0000, 12'h0);
        tbl[7]  = mk(32'h3000_7000, 1, 32'hFF, 4'b0001, 1, 32'h0, 4'b0000, 12'h0);
        tbl[8]  = mk(32'h3000_7000, 0, 32'h0, 4'hF, 1, 32'h0000_000F, 4'b0000, 12'h0);
        tbl[9]  = mk(32'h3000_7000, 1, 32'h0, 4'b1110, 1, 32'h0, 4'b0000, 12'h0);
        tbl[10] = mk(32'h3000_7000, 0, 32'h0, 4'hF, 1, 32'h0000_000F, 4'b0000, 12'h0);
        tbl[11] = mk(32'h3100_1000, 0, 32'h0, 4'hF, -1, 32'h0, 4'b0000, 12'h0);
        tbl[12] = mk(32'h3000_7000, 1, 32'h1, 4'b0001, 1, 32'h0, 4'b0000, 12'h0);
        tbl[13] = mk(32'h3000_7004, 0, 32'h0, 4'hF, 1, 32'h0, 4'b0000, 12'h0);
        tbl[14] = mk(32'h3000_7008, 0, 32'h0, 4'hF, 1, 32'h0, 4'b0000, 12'h0);

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_stb", 32'({ch_stb, ch_cyc}), 32'd0);
        check("rst_irq", 32'(user_irq), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            xfer(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].s, 10, r, lat, sst, sadr, cd);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("vec%0d_stb", i), 32'(sst), 32'(tbl[i].stb));
            if (!tbl[i].w && tbl[i].lat > 0) check($sformatf("vec%0d_rdat", i), r, tbl[i].rd);
            if (tbl[i].stb != 0) check($sformatf("vec%0d_cadr", i), 32'(sadr), 32'(tbl[i].cadr));
            if (tbl[i].stb != 0 && tbl[i].w) check($sformatf("vec%0d_cdat", i), cd, tbl[i].d);
        end
        m_mask = 4'h1; m_pend = '0; m_tmo = '0;

        // Random traffic against the register-level model (channel 2 excluded: it never acks)
        for (int n = 0; n < 40; n++) begin
            int          pick, idx;
            logic [11:0] off;
            logic        w;
            logic [31:0] d;
            logic [3:0]  s;
            int          exp_lat;
            logic [31:0] exp_rd;
            logic [3:0]  exp_stb;
            pick = int'($urandom_range(0, 6));
            idx  = (pick < 2) ? pick : pick + 1;
            off  = 12'($urandom) & 12'hFFC;
            w    = 1'($urandom);
            d    = $urandom;
            s    = 4'($urandom);
            exp_stb = '0;
            if (idx < int'(NCH)) begin
                exp_lat = 2; exp_rd = chan_data[idx]; exp_stb = 4'(1 << idx);
            end else if (idx == 7) begin
                exp_lat = 1; exp_rd = model_ctrl(off[3:2]);
                if (w && s[0]) begin
                    case (off[3:2])
                        2'd0:    m_mask = d[NCH-1:0];
                        2'd1:    m_pend = m_pend & ~d[NCH-1:0];
                        2'd2:    m_tmo  = m_tmo & ~d[NCH-1:0];
                        default: ;
                    endcase
                end
            end else begin
                exp_lat = 1; exp_rd = 32'hDEAD_BEEF;
            end
            xfer({8'h30, 9'd0, 3'(idx), off}, w, d, s, 10, r, lat, sst, sadr, cd);
            check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(exp_lat));
            check($sformatf("rnd%0d_stb", n), 32'(sst), 32'(exp_stb));
            if (!w) check($sformatf("rnd%0d_rdat", n), r, exp_rd);
            if (exp_stb != 0) check($sformatf("rnd%0d_cadr", n), 32'(sadr), 32'(off));
        end

        // Timeout on a silent channel, then W1C of the status
        xfer(32'h3000_2000, 0, 0, 4'hF, 400, r, lat, sst, sadr, cd);
        check("tmo_lat", 32'(lat), 32'(TMO + 1));
        check("tmo_rdat", r, 32'hDEAD_BEEF);
        check("tmo_stb", 32'(sst), 32'h4);
        xfer(32'h3000_7008, 0, 0, 4'hF, 10, r, lat, sst, sadr, cd);
        check("tmo_status", r, 32'h4);
        check("tmo_irq1", 32'(user_irq[1]), 32'd1);
        xfer(32'h3000_7008, 1, 32'h4, 4'h1, 10, r, lat, sst, sadr, cd);
        xfer(32'h3000_7008, 0, 0, 4'hF, 10, r, lat, sst, sadr, cd);
        check("tmo_cleared", r, 32'h0);
        check("tmo_irq1_clr", 32'(user_irq[1]), 32'd0);

        // Ack arriving in the same cycle as the timeout wins
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_2000; sel = 4'hF;
        @(posedge clk);
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("coin_still_fwd", 32'(ch_stb), 32'h4);
        ack_force = 4'b0100;
        @(posedge clk); #1;
        ack_force = '0;
        check("coin_no_ack_yet", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        check("coin_ack", {31'd0, ack}, 32'd1);
        check("coin_rdat", rdat, 32'hC0DE_2222);
        cyc = 0; stb = 0;
        xfer(32'h3000_7008, 0, 0, 4'hF, 10, r, lat, sst, sadr, cd);
        check("coin_no_tmo", r, 32'h0);

        // IRQ pending and same-cycle set/W1C
        xfer(32'h3000_7000, 1, 32'h1, 4'h1, 10, r, lat, sst, sadr, cd);
        @(negedge clk); ch_irq[0] = 1'b1;
        @(negedge clk); ch_irq[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("irq0_user", 32'(user_irq[0]), 32'd1);
        xfer(32'h3000_7004, 0, 0, 4'hF, 10, r, lat, sst, sadr, cd);
        check("irq_pend", r, 32'h1);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = 32'h3000_7004; wdat = 32'h1; sel = 4'h1;
        @(posedge clk);
        @(negedge clk); ch_irq[0] = 1'b1;
        @(posedge clk); #1;
        check("w1c_ack", {31'd0, ack}, 32'd1);
        cyc = 0; stb = 0; we = 0;
        xfer(32'h3000_7004, 0, 0, 4'hF, 10, r, lat, sst, sadr, cd);
        check("w1c_race_pend", r, 32'h1);
        @(negedge clk); ch_irq[0] = 1'b0;
        xfer(32'h3000_7004, 1, 32'h1, 4'h1, 10, r, lat, sst, sadr, cd);
        xfer(32'h3000_7004, 0, 0, 4'hF, 10, r, lat, sst, sadr, cd);
        check("w1c_clear", r, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("irq0_user_clr", 32'(user_irq[0]), 32'd0);

        // Upstream abort during FWD
        ack_en = 4'b1001;
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_1000; sel = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("abort_stb", 32'(ch_stb), 32'h2);
        cyc = 0; stb = 0;
        @(posedge clk); #1;
        check("abort_stb_drop", 32'(ch_stb), 32'h0);
        for (int k = 0; k < 3; k++) begin
            check("abort_no_ack", {31'd0, ack}, 32'd0);
            @(posedge clk); #1;
        end
        ack_en = 4'b1011;
        xfer(32'h3000_1000, 0, 0, 4'hF, 10, r, lat, sst, sadr, cd);
        check("abort_next_lat", 32'(lat), 32'd2);
        check("abort_next_rdat", r, 32'hC0DE_1111);

        // Reset during FWD
        ack_en = 4'b1001;
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_1000; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("rstfwd_stb", 32'(ch_stb), 32'h2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstfwd_stb_drop", 32'(ch_stb), 32'h0);
        check("rstfwd_no_ack", {31'd0, ack}, 32'd0);
        check("rstfwd_irq", 32'(user_irq), 32'd0);
        cyc = 0; stb = 0;
        @(negedge clk); rst_n = 1'b1;
        ack_en = 4'b1011;
        xfer(32'h3000_7000, 0, 0, 4'hF, 10, r, lat, sst, sadr, cd);
        check("rstfwd_mask", r, 32'h0);
        xfer(32'h3000_1000, 0, 0, 4'hF, 10, r, lat, sst, sadr, cd);
        check("rstfwd_next_lat", 32'(lat), 32'd2);
        check("rstfwd_next_rdat", r, 32'hC0DE_1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
